// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB pipeline register, writeback select, 8-entry register file
// with write-through read bypass, forwarding port to execute, and retired-write counter.
module writeback_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IRegWrite,
    input  logic                  IRegStore,
    input  logic [DATA_W-1:0]     IALUResult,
    input  logic [DATA_W-1:0]     StoreMem,
    input  logic [REG_ADDR_W-1:0] rdWB,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [15:0]           retired
);

    logic                  wb_we_q, wb_we_d;
    logic                  wb_sel_q, wb_sel_d;
    logic [DATA_W-1:0]     wb_alu_q, wb_alu_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  committed_q, committed_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [15:0]           retired_q, retired_d;

    logic [DATA_W-1:0]     wb_data;
    logic                  pending;
    logic                  commit;

    // StoreMem comes straight from the synchronous RAM and already lines up with WB.
    assign wb_data = wb_sel_q ? StoreMem : wb_alu_q;
    assign pending = wb_we_q & ~committed_q;
    assign commit  = pending & (wb_rd_q != '0);

    always_comb begin
        wb_we_d  = wb_we_q;
        wb_sel_d = wb_sel_q;
        wb_alu_d = wb_alu_q;
        wb_rd_d  = wb_rd_q;
        if (flush || !stall) begin
            wb_we_d  = flush ? 1'b0 : IRegWrite;
            wb_sel_d = IRegStore;
            wb_alu_d = IALUResult;
            wb_rd_d  = rdWB;
        end
    end

    // A held entry commits once; the flag drops as soon as a new entry loads.
    always_comb begin
        committed_d = committed_q;
        if (flush || !stall)
            committed_d = 1'b0;
        else if (commit)
            committed_d = 1'b1;
    end

    always_comb begin
        regs_d    = regs_q;
        retired_d = retired_q;
        if (commit) begin
            regs_d[wb_rd_q] = wb_data;
            retired_d       = retired_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_we_q     <= 1'b0;
            wb_sel_q    <= 1'b0;
            wb_alu_q    <= '0;
            wb_rd_q     <= '0;
            committed_q <= 1'b0;
            regs_q      <= '0;
            retired_q   <= '0;
        end else begin
            wb_we_q     <= wb_we_d;
            wb_sel_q    <= wb_sel_d;
            wb_alu_q    <= wb_alu_d;
            wb_rd_q     <= wb_rd_d;
            committed_q <= committed_d;
            regs_q      <= regs_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rs1 != '0)
            rdata1 = (pending && rs1 == wb_rd_q) ? wb_data : regs_q[rs1];
        if (rs2 != '0)
            rdata2 = (pending && rs2 == wb_rd_q) ? wb_data : regs_q[rs2];
    end

    assign fwd_valid = commit;
    assign fwd_rd    = wb_rd_q;
    assign fwd_data  = wb_data;
    assign retired   = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected WB entries are queued at issue
// and compared against the forwarding port and read bypass in the WB cycle.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        IRegWrite, IRegStore, stall, flush;
    logic [15:0] IALUResult, StoreMem;
    logic [2:0]  rdWB, rs1, rs2;
    logic [15:0] rdata1, rdata2, fwd_data, retired;
    logic        fwd_valid;
    logic [2:0]  fwd_rd;

    typedef struct {
        logic        vld;
        logic [2:0]  rd;
        logic [15:0] data;
    } wb_exp_t;

    wb_exp_t     sb_q[$];
    logic [15:0] exp_regs[8];
    logic [15:0] exp_retired;
    int          n_tests = 0;
    int          n_fail  = 0;

    writeback_stage dut (
        .clk(clk), .reset(reset),
        .IRegWrite(IRegWrite), .IRegStore(IRegStore),
        .IALUResult(IALUResult), .StoreMem(StoreMem), .rdWB(rdWB),
        .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
        .rdata1(rdata1), .rdata2(rdata2),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0;
        exp_retired = 16'h0;
        sb_q.delete();
    endtask

    // Issue one memory-stage entry, then check it in its WB cycle on both read ports.
    task automatic wb_op(input logic we, input logic sel, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [2:0] rd);
        wb_exp_t e;
        wb_exp_t p;
        @(negedge clk);
        IRegWrite = we; IRegStore = sel; IALUResult = alu; rdWB = rd;
        stall = 1'b0; flush = 1'b0;
        e.vld = we && (rd != 3'd0); e.rd = rd; e.data = sel ? mem : alu;
        sb_q.push_back(e);
        @(negedge clk);
        IRegWrite = 1'b0; IALUResult = 16'h0; rdWB = 3'd0;
        StoreMem = mem; rs1 = rd; rs2 = rd;
        #1;
        p = sb_q.pop_front();
        chk("fwd_valid", {31'b0, fwd_valid}, {31'b0, p.vld});
        chk("fwd_rd", {29'b0, fwd_rd}, {29'b0, p.rd});
        chk("fwd_data", {16'b0, fwd_data}, {16'b0, p.data});
        chk("bypass_rdata1", {16'b0, rdata1}, {16'b0, p.vld ? p.data : exp_regs[p.rd]});
        chk("bypass_rdata2", {16'b0, rdata2}, {16'b0, p.vld ? p.data : exp_regs[p.rd]});
        if (p.vld) begin
            exp_regs[p.rd] = p.data;
            exp_retired    = exp_retired + 16'd1;
        end
    endtask

    task automatic chk_state(input string tag);
        @(negedge clk);
        for (int r = 0; r < 8; r++) begin
            rs1 = r[2:0]; rs2 = 3'(7 - r);
            #1;
            chk({tag, "_rdata1"}, {16'b0, rdata1}, {16'b0, exp_regs[r]});
            chk({tag, "_rdata2"}, {16'b0, rdata2}, {16'b0, exp_regs[7-r]});
        end
        chk({tag, "_retired"}, {16'b0, retired}, {16'b0, exp_retired});
    endtask

    initial begin
        reset = 1'b0;
        IRegWrite = 1'b0; IRegStore = 1'b0; IALUResult = 16'h0; StoreMem = 16'h0;
        rdWB = 3'd0; stall = 1'b0; flush = 1'b0; rs1 = 3'd0; rs2 = 3'd0;
        clr_model();

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk_state("reset");
        chk("reset_fwd_valid", {31'b0, fwd_valid}, 32'd0);
        chk("reset_fwd_rd", {29'b0, fwd_rd}, 32'd0);
        chk("reset_fwd_data", {16'b0, fwd_data}, 32'd0);

        // ALU writeback, load writeback, x0 write
        wb_op(1'b1, 1'b0, 16'h1234, 16'hAAAA, 3'd3);
        chk_state("alu_wb");
        wb_op(1'b1, 1'b1, 16'h5555, 16'hBEEF, 3'd5);
        chk_state("load_wb");
        wb_op(1'b1, 1'b0, 16'hFFFF, 16'h0000, 3'd0);
        chk_state("x0_wb");
        wb_op(1'b0, 1'b0, 16'h7777, 16'h0000, 3'd6);
        wb_op(1'b1, 1'b1, 16'h0000, 16'hC0DE, 3'd6);
        chk_state("mixed");

        // stall: rd=2 val 7 held for 3 cycles commits once
        @(negedge clk);
        IRegWrite = 1'b1; IRegStore = 1'b0; IALUResult = 16'h0007; rdWB = 3'd2;
        @(negedge clk);
        stall = 1'b1; IALUResult = 16'h0099; rdWB = 3'd6; rs1 = 3'd2;
        #1;
        chk("stall_fwd_valid_first", {31'b0, fwd_valid}, 32'd1);
        chk("stall_bypass", {16'b0, rdata1}, 32'h0007);
        exp_regs[2] = 16'h0007;
        exp_retired = exp_retired + 16'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rs1 = 3'd2;
            #1;
            chk("stall_fwd_valid_held", {31'b0, fwd_valid}, 32'd0);
            chk("stall_reg2", {16'b0, rdata1}, 32'h0007);
            chk("stall_retired", {16'b0, retired}, {16'b0, exp_retired});
        end
        IRegWrite = 1'b0; stall = 1'b0;
        chk_state("after_stall");

        // flush wins over stall: rd=4 write becomes a bubble
        @(negedge clk);
        IRegWrite = 1'b1; IALUResult = 16'h4444; rdWB = 3'd4; flush = 1'b1; stall = 1'b1;
        @(negedge clk);
        IRegWrite = 1'b0; flush = 1'b0; stall = 1'b0; rs1 = 3'd4;
        #1;
        chk("flush_fwd_valid", {31'b0, fwd_valid}, 32'd0);
        chk("flush_rdata1", {16'b0, rdata1}, {16'b0, exp_regs[4]});
        chk_state("after_flush");

        // async reset between edges while an entry waits to commit
        @(negedge clk);
        IRegWrite = 1'b1; IRegStore = 1'b0; IALUResult = 16'h0101; rdWB = 3'd1;
        @(negedge clk);
        IRegWrite = 1'b0; rs1 = 3'd1; rs2 = 3'd5;
        #1;
        chk("pre_reset_fwd_valid", {31'b0, fwd_valid}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_fwd_valid", {31'b0, fwd_valid}, 32'd0);
        chk("async_fwd_data", {16'b0, fwd_data}, 32'd0);
        chk("async_rdata1", {16'b0, rdata1}, 32'd0);
        chk("async_rdata2", {16'b0, rdata2}, 32'd0);
        chk("async_retired", {16'b0, retired}, 32'd0);
        #1 reset = 1'b1;
        clr_model();
        chk_state("after_async");

        // drive 0xFFFF back-to-back commits, then one more to wrap the counter
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            IRegWrite = 1'b1; IRegStore = 1'b0; rdWB = 3'd7; IALUResult = i[15:0];
        end
        @(negedge clk);
        IRegWrite = 1'b0;
        exp_retired = exp_retired + 16'hFFFF;
        exp_regs[7] = 16'hFFFE;
        chk_state("pre_wrap");
        wb_op(1'b1, 1'b0, 16'h0ABC, 16'h0000, 3'd7);
        chk_state("wrap");
        chk("wrap_zero", {16'b0, retired}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; consumes the memory stage's outputs (register-write enable, memory-select, ALU result, memory read data, destination register).
- Contains the MEM/WB pipeline register, the writeback data select, the 8-entry architectural register file with write-through bypass on its read ports, a forwarding port back to execute, and a retired-write counter.
- Memory read data comes from a synchronous-read RAM. It arrives one cycle after its address, so it lines up with the MEM/WB register outputs and is not registered here.

Parameters:
- DATA_W, 16, datapath width
- REG_ADDR_W, 3, register index width
- NUM_REGS, 8, register file depth (2**REG_ADDR_W)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- IRegWrite  in  1  memory-stage register-write enable
- IRegStore  in  1  1 = write back memory data, 0 = write back ALU result
- IALUResult  in  DATA_W  memory-stage ALU result
- StoreMem  in  DATA_W  RAM read data, valid in the WB cycle
- rdWB  in  REG_ADDR_W  destination register
- stall  in  1  hold the MEM/WB register
- flush  in  1  insert a bubble into MEM/WB
- rs1  in  REG_ADDR_W  read port 1 address
- rs2  in  REG_ADDR_W  read port 2 address
- rdata1  out  DATA_W  read port 1 data
- rdata2  out  DATA_W  read port 2 data
- fwd_valid  out  1  WB stage will write a nonzero register this cycle
- fwd_rd  out  REG_ADDR_W  WB destination register
- fwd_data  out  DATA_W  WB write data
- retired  out  16  count of committed register writes

Behaviour:
- Reset (reset=0, asynchronous):
  - MEM/WB register cleared: wb_we=0, wb_sel=0, wb_alu=0, wb_rd=0.
  - All NUM_REGS registers cleared to 0; retired=0.
  - Outputs: fwd_valid=0, fwd_rd=0, fwd_data=0; rdata1/rdata2=0 for any address.
  - Deasserting reset mid-stream restarts from this empty state. No pending write survives.
- MEM/WB capture on rising clk, priority flush > stall > load:
  - flush=1: wb_we<=0; other fields load normally.
  - stall=1 (and flush=0): all fields hold.
  - Otherwise: wb_we<=IRegWrite, wb_sel<=IRegStore, wb_alu<=IALUResult, wb_rd<=rdWB.
- Writeback data is combinational: wb_data = wb_sel ? StoreMem : wb_alu.
  - StoreMem is sampled in the cycle after the matching IALUResult was captured. Latency from memory-stage outputs to register-file commit is 1 cycle.
- Commit on rising clk:
  - When wb_we=1 and wb_rd!=0: regs[wb_rd]<=wb_data and retired<=retired+1.
  - retired wraps from 0xFFFF to 0x0000.
- Commit while stalled:
  - A held entry must not commit twice.
  - Commit is gated by a 1-bit "committed" flag. It is set on commit while stall=1 and cleared on any non-stalled MEM/WB load.
- Register 0 reads as 0 always; writes to it are dropped and are not counted.
- Read ports are combinational:
  - rdataN = 0 if rsN=0.
  - Else wb_data if the WB entry is about to commit (wb_we=1, not yet committed) and rsN=wb_rd. This is the write-through bypass.
  - Else regs[rsN].
- Forwarding outputs:
  - fwd_valid = wb_we & (wb_rd!=0) & ~committed.
  - fwd_rd = wb_rd; fwd_data = wb_data.
- Simultaneous flush and stall: flush wins, so the entry becomes a bubble.
- rs1 = rs2 = wb_rd: both ports bypass.

Test Plan:
- Reset behaviour: reset=0 for 2 cycles, then 1 -> rdata1/rdata2=0 for all rs1/rs2 in 0..7, retired=0, fwd_valid=0.
- ALU writeback: IRegWrite=1, IRegStore=0, IALUResult=0x1234, rdWB=3, then rs1=3 -> fwd_valid=1, fwd_rd=3, rdata1=0x1234 via bypass in the WB cycle. After the next edge, rdata1=0x1234 from the file and retired=1.
- Load writeback: IRegStore=1, rdWB=5, StoreMem=0xBEEF driven in the WB cycle -> reg5=0xBEEF, not IALUResult.
- x0 write: IRegWrite=1, rdWB=0, IALUResult=0xFFFF -> fwd_valid=0, rdata1(rs1=0)=0, retired unchanged.
- Stall/flush: write rd=2 val 0x0007, then stall=1 for 3 cycles -> reg2=0x0007 and retired increments exactly once. With flush=1 and stall=1 together on an rd=4 write -> reg4 unchanged.
- Counter wrap: preload so retired=0xFFFF, commit one write -> retired=0x0000.
- Async reset mid-commit: assert reset=0 between clock edges while wb_we=1 -> outputs clear immediately, and the entry does not commit after release.
